// File: rtl/xvec2_md_sequencer_pkg.sv
// Shared types and encodings for the xvec2 vector mul/div sequencer.
// Operation/output-select encodings mirror the scalar mul/div unit.
package xvec2_md_sequencer_pkg;

    localparam int MD_OP_WIDTH      = 2;
    localparam int MD_OUT_SEL_WIDTH = 2;

    localparam logic [MD_OP_WIDTH-1:0] MD_OP_MUL = 2'd0;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV = 2'd1;
    localparam logic [MD_OP_WIDTH-1:0] MD_OP_REM = 2'd2;

    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_SEL_LO  = 2'd0;
    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_SEL_HI  = 2'd1;
    localparam logic [MD_OUT_SEL_WIDTH-1:0] MD_OUT_SEL_REM = 2'd2;

    localparam int SEQ_STATE_WIDTH = 3;

    typedef enum logic [SEQ_STATE_WIDTH-1:0] {
        SEQ_IDLE  = 3'd0,
        SEQ_ISSUE = 3'd1,
        SEQ_WAIT  = 3'd2,
        SEQ_DONE  = 3'd3,
        SEQ_DRAIN = 3'd4
    } seq_state_e;

    // Controls latched once per vector and replayed for every element.
    typedef struct packed {
        logic [MD_OP_WIDTH-1:0]      op;
        logic [MD_OUT_SEL_WIDTH-1:0] out_sel;
        logic                        in_1_signed;
        logic                        in_2_signed;
    } md_ctrl_t;

endpackage

// File: rtl/xvec2_md_sequencer.sv
// Runs one vector mul/div as NUM_ELEMS back-to-back scalar operations on a
// shared multi-cycle unit, gathering element results into a packed vector.
module xvec2_md_sequencer
    import xvec2_md_sequencer_pkg::*;
#(
    parameter int NUM_ELEMS  = 2,
    parameter int ELEM_WIDTH = 32,
    parameter int IDX_WIDTH  = (NUM_ELEMS > 2) ? $clog2(NUM_ELEMS) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [MD_OP_WIDTH-1:0]          req_op,
    input  logic [MD_OUT_SEL_WIDTH-1:0]     req_out_sel,
    input  logic                            req_in_1_signed,
    input  logic                            req_in_2_signed,
    input  logic [NUM_ELEMS*ELEM_WIDTH-1:0] req_in_1,
    input  logic [NUM_ELEMS*ELEM_WIDTH-1:0] req_in_2,
    input  logic                            kill,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic [NUM_ELEMS*ELEM_WIDTH-1:0] resp_result,
    output logic                            md_req_valid,
    input  logic                            md_req_ready,
    output logic [MD_OP_WIDTH-1:0]          md_req_op,
    output logic [MD_OUT_SEL_WIDTH-1:0]     md_req_out_sel,
    output logic                            md_req_in_1_signed,
    output logic                            md_req_in_2_signed,
    output logic [ELEM_WIDTH-1:0]           md_req_in_1,
    output logic [ELEM_WIDTH-1:0]           md_req_in_2,
    input  logic                            md_resp_valid,
    input  logic [ELEM_WIDTH-1:0]           md_resp_result,
    output logic                            busy
);

    typedef logic [NUM_ELEMS-1:0][ELEM_WIDTH-1:0] vec_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_ELEMS - 1);

    seq_state_e           state;
    logic [IDX_WIDTH-1:0] idx;
    md_ctrl_t             ctrl_q;
    vec_t                 in_1_q;
    vec_t                 in_2_q;
    vec_t                 res_q;

    // All handshake outputs decode straight from the state register; only
    // req_ready also looks at kill so a killed cycle never accepts.
    assign req_ready    = (state == SEQ_IDLE) && !kill;
    assign resp_valid   = (state == SEQ_DONE);
    assign md_req_valid = (state == SEQ_ISSUE);
    assign busy         = (state != SEQ_IDLE);

    assign resp_result        = res_q;
    assign md_req_op          = ctrl_q.op;
    assign md_req_out_sel     = ctrl_q.out_sel;
    assign md_req_in_1_signed = ctrl_q.in_1_signed;
    assign md_req_in_2_signed = ctrl_q.in_2_signed;
    assign md_req_in_1        = in_1_q[idx];
    assign md_req_in_2        = in_2_q[idx];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= SEQ_IDLE;
            idx    <= '0;
            ctrl_q <= '0;
            in_1_q <= '0;
            in_2_q <= '0;
            res_q  <= '0;
        end else begin
            case (state)
                SEQ_IDLE: begin
                    if (req_valid && req_ready) begin
                        ctrl_q <= '{op: req_op, out_sel: req_out_sel,
                                   in_1_signed: req_in_1_signed,
                                   in_2_signed: req_in_2_signed};
                        in_1_q <= req_in_1;
                        in_2_q <= req_in_2;
                        idx    <= '0;
                        state  <= SEQ_ISSUE;
                    end
                end
                SEQ_ISSUE: begin
                    // A kill racing the handshake leaves a unit op in flight.
                    if (kill)
                        state <= md_req_ready ? SEQ_DRAIN : SEQ_IDLE;
                    else if (md_req_ready)
                        state <= SEQ_WAIT;
                end
                SEQ_WAIT: begin
                    if (md_resp_valid) begin
                        if (kill) begin
                            state <= SEQ_IDLE;
                        end else begin
                            res_q[idx] <= md_resp_result;
                            if (idx == LAST_IDX) begin
                                state <= SEQ_DONE;
                            end else begin
                                idx   <= idx + IDX_WIDTH'(1);
                                state <= SEQ_ISSUE;
                            end
                        end
                    end else if (kill) begin
                        state <= SEQ_DRAIN;
                    end
                end
                SEQ_DONE: begin
                    if (kill || resp_ready)
                        state <= SEQ_IDLE;
                end
                SEQ_DRAIN: begin
                    if (md_resp_valid)
                        state <= SEQ_IDLE;
                end
                default: state <= SEQ_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_xvec2_md_sequencer.sv
// Directed + randomized bench for xvec2_md_sequencer with a behavioural
// mul/div unit and an element-wise arithmetic reference.
module tb_xvec2_md_sequencer;
    import xvec2_md_sequencer_pkg::*;

    localparam int NE = 2;
    localparam int EW = 32;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = '0;
    logic [1:0]    req_out_sel = '0;
    logic          req_in_1_signed = 1'b0;
    logic          req_in_2_signed = 1'b0;
    logic [63:0]   req_in_1 = '0;
    logic [63:0]   req_in_2 = '0;
    logic          kill = 1'b0;
    logic          resp_valid;
    logic          resp_ready = 1'b0;
    logic [63:0]   resp_result;
    logic          md_req_valid;
    logic          md_req_ready = 1'b0;
    logic [1:0]    md_req_op;
    logic [1:0]    md_req_out_sel;
    logic          md_req_in_1_signed;
    logic          md_req_in_2_signed;
    logic [31:0]   md_req_in_1;
    logic [31:0]   md_req_in_2;
    logic          md_resp_valid = 1'b0;
    logic [31:0]   md_resp_result = '0;
    logic          busy;

    xvec2_md_sequencer #(.NUM_ELEMS(NE), .ELEM_WIDTH(EW), .IDX_WIDTH(1)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_out_sel(req_out_sel), .req_in_1_signed(req_in_1_signed),
        .req_in_2_signed(req_in_2_signed), .req_in_1(req_in_1), .req_in_2(req_in_2),
        .kill(kill), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_result(resp_result), .md_req_valid(md_req_valid),
        .md_req_ready(md_req_ready), .md_req_op(md_req_op),
        .md_req_out_sel(md_req_out_sel), .md_req_in_1_signed(md_req_in_1_signed),
        .md_req_in_2_signed(md_req_in_2_signed), .md_req_in_1(md_req_in_1),
        .md_req_in_2(md_req_in_2), .md_resp_valid(md_resp_valid),
        .md_resp_result(md_resp_result), .busy(busy)
    );

    always #5 clk = ~clk;

    int errs = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Arithmetic reference for one element, from operand values and controls.
    function automatic logic [31:0] calc(input logic [1:0] op, input logic [1:0] sel,
                                         input logic s1, input logic s2,
                                         input logic [31:0] a, input logic [31:0] b);
        logic signed [32:0] ea, eb, q, r;
        logic signed [65:0] p;
        ea = s1 ? {a[31], a} : {1'b0, a};
        eb = s2 ? {b[31], b} : {1'b0, b};
        if (op == MD_OP_MUL) begin
            p = ea * eb;
            return (sel == MD_OUT_SEL_HI) ? p[63:32] : p[31:0];
        end
        if (b == 32'd0) begin
            q = '1;
            r = ea;
        end else begin
            q = ea / eb;
            r = ea % eb;
        end
        return (sel == MD_OUT_SEL_REM) ? r[31:0] : q[31:0];
    endfunction

    // Unit model controls (written only by the main initial block).
    int lat = 1;
    int stall_at = -1;
    int stall_n = 0;
    bit force_nr = 1'b0;

    // Unit model state (written only by the unit process).
    int          hs_cnt = 0;
    logic [63:0] hs_q[$];
    int          cnt = 0;
    logic [31:0] pend = '0;
    int          stall_ctr = 0;
    logic [63:0] snap = '0;
    int          stall_mis = 0;

    always @(negedge clk) begin
        md_resp_valid = 1'b0;
        if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                md_resp_valid  = 1'b1;
                md_resp_result = pend;
            end
        end
        if (hs_cnt != stall_at) stall_ctr = 0;
        if (force_nr) begin
            md_req_ready = 1'b0;
        end else if (md_req_valid && hs_cnt == stall_at && stall_ctr < stall_n) begin
            md_req_ready = 1'b0;
            if (stall_ctr == 0) snap = {md_req_in_2, md_req_in_1};
            else if (snap !== {md_req_in_2, md_req_in_1}) stall_mis++;
            stall_ctr++;
        end else begin
            md_req_ready = 1'b1;
        end
        if (md_req_valid && md_req_ready) begin
            if (stall_ctr > 0 && snap !== {md_req_in_2, md_req_in_1}) stall_mis++;
            hs_q.push_back({md_req_in_2, md_req_in_1});
            hs_cnt++;
            cnt  = lat;
            pend = calc(md_req_op, md_req_out_sel, md_req_in_1_signed,
                        md_req_in_2_signed, md_req_in_1, md_req_in_2);
        end
    end

    int base = 0;

    // Presents one request in the current cycle (cycle 0); returns in cycle 1.
    task automatic start(input logic [1:0] op, input logic [1:0] sel, input logic s1,
                         input logic s2, input logic [63:0] a, input logic [63:0] b);
        int n = 0;
        while (!req_ready && n < 50) begin step(); n++; end
        chk("accept_ready", 64'(req_ready), 64'd1);
        base = hs_cnt;
        req_valid = 1'b1; req_op = op; req_out_sel = sel;
        req_in_1_signed = s1; req_in_2_signed = s2; req_in_1 = a; req_in_2 = b;
        step();
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input logic [1:0] op, input logic [1:0] sel, input logic s1,
                           input logic s2, input logic [63:0] a, input logic [63:0] b,
                           input int l, input int st_e, input int st_n, input int hold);
        logic [63:0] ev;
        int n;
        for (int e = 0; e < NE; e++)
            ev[e*EW +: EW] = calc(op, sel, s1, s2, a[e*EW +: EW], b[e*EW +: EW]);
        lat = l; stall_at = hs_cnt + st_e; stall_n = st_n;
        start(op, sel, s1, s2, a, b);
        n = 1;
        while (!resp_valid && n < 200) begin step(); n++; end
        chk("latency", 64'(n), 64'(1 + NE * (1 + l) + st_n));
        chk("resp_valid", 64'(resp_valid), 64'd1);
        chk("result", resp_result, ev);
        chk("done_req_ready", 64'(req_ready), 64'd0);
        chk("hs_count", 64'(hs_cnt - base), 64'(NE));
        for (int e = 0; e < NE; e++)
            chk("hs_elem", hs_q[base + e], {b[e*EW +: EW], a[e*EW +: EW]});
        repeat (hold) begin
            req_valid = 1'b1;
            step();
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_result", resp_result, ev);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("done_exit", {62'd0, resp_valid, busy}, 64'd0);
        stall_n = 0;
    endtask

    initial begin
        int n;
        bit seen;
        logic [1:0] op, sel;
        logic [63:0] a, b;

        // Reset state
        repeat (2) step();
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_outs", {61'd0, resp_valid, md_req_valid, busy}, 64'd0);
        chk("rst_result", resp_result, 64'd0);
        reset_n = 1'b1;
        step();

        // 1: MUL, L=1, latency 5
        run_vec(MD_OP_MUL, MD_OUT_SEL_LO, 1'b0, 1'b0, {32'd7, 32'd3}, {32'd6, 32'd5}, 1, 0, 0, 0);
        chk("t1_const", resp_result, {32'd42, 32'd15});

        // 2: signed DIV with a 3-cycle issue stall on element 1
        run_vec(MD_OP_DIV, MD_OUT_SEL_LO, 1'b1, 1'b1, {-32'sd9, 32'd100}, {32'd2, 32'd7}, 1, 1, 3, 0);
        chk("t2_const", resp_result, {-32'sd4, 32'd14});
        chk("stall_stable", 64'(stall_mis), 64'd0);

        // 3: response held 4 cycles against a pending request
        run_vec(MD_OP_REM, MD_OUT_SEL_REM, 1'b1, 1'b0, {32'd100, 32'hFFFF_FFF9},
                {32'd9, 32'd4}, 2, 0, 0, 4);

        // Kill in IDLE blocks acceptance
        kill = 1'b1; req_valid = 1'b1;
        #1 chk("idle_kill_ready", 64'(req_ready), 64'd0);
        step();
        chk("idle_kill_busy", 64'(busy), 64'd0);
        kill = 1'b0; req_valid = 1'b0;

        // 4: kill in WAIT of element 0, response arrives 3 cycles later
        lat = 4;
        start(MD_OP_MUL, MD_OUT_SEL_LO, 1'b0, 1'b0, 64'd11, 64'd12);
        step();
        chk("t4_wait", {62'd0, busy, md_req_valid}, 64'd2);
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("t4_drain", {62'd0, busy, md_req_valid}, 64'd2);
        n = 3; seen = 1'b0;
        while (busy && n < 50) begin seen |= resp_valid; step(); n++; end
        chk("t4_drain_exit", 64'(n), 64'd6);
        chk("t4_no_resp", 64'(seen | resp_valid), 64'd0);
        chk("t4_ready", 64'(req_ready), 64'd1);
        run_vec(MD_OP_MUL, MD_OUT_SEL_HI, 1'b1, 1'b1, {32'h8000_0000, 32'hFFFF_FFFF},
                {32'h7FFF_FFFF, 32'd5}, 1, 0, 0, 0);

        // 5a: kill in the same cycle as the issue handshake
        lat = 2;
        start(MD_OP_DIV, MD_OUT_SEL_LO, 1'b0, 1'b0, 64'd20, 64'd4);
        kill = 1'b1;
        step();
        kill = 1'b0;
        chk("t5a_drain", {62'd0, busy, md_req_valid}, 64'd2);
        n = 2;
        while (busy && n < 50) begin step(); n++; end
        chk("t5a_exit", 64'(n), 64'd4);
        chk("t5a_hs", 64'(hs_cnt - base), 64'd1);

        // 5b: kill in ISSUE while the unit is not ready
        force_nr = 1'b1;
        start(MD_OP_DIV, MD_OUT_SEL_LO, 1'b0, 1'b0, 64'd20, 64'd4);
        chk("t5b_issue", 64'(md_req_valid), 64'd1);
        kill = 1'b1;
        step();
        kill = 1'b0;
        force_nr = 1'b0;
        chk("t5b_idle", {62'd0, busy, md_req_valid}, 64'd0);
        chk("t5b_hs", 64'(hs_cnt - base), 64'd0);

        // 6: async reset mid-WAIT, stray unit response afterwards
        lat = 3;
        start(MD_OP_MUL, MD_OUT_SEL_LO, 1'b0, 1'b0, {32'd2, 32'd3}, {32'd4, 32'd5});
        step();
        chk("t6_wait", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_outs", {60'd0, req_ready, resp_valid, md_req_valid, busy}, 64'd8);
        chk("t6_rst_result", resp_result, 64'd0);
        step();
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (4) begin step(); seen |= busy | resp_valid; end
        chk("t6_stray_ignored", 64'(seen), 64'd0);

        // Randomized vectors
        for (int i = 0; i < 12; i++) begin
            op  = 2'($urandom_range(0, 2));
            sel = (op == MD_OP_MUL) ? 2'($urandom_range(0, 1)) :
                  (op == MD_OP_DIV) ? MD_OUT_SEL_LO : MD_OUT_SEL_REM;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 5) == 0) b[31:0] = '0;
            if ($urandom_range(0, 3) == 0) b[63:32] = {28'd0, 4'($urandom)};
            run_vec(op, sel, 1'($urandom), 1'($urandom), a, b, $urandom_range(1, 3),
                    $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 2));
        end
        chk("rand_stall_stable", 64'(stall_mis), 64'd0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", errs, checks);
        $fatal(1, "timeout");
    end

endmodule
